// File: rtl/vector_feeder.sv
// vector_feeder
// Upstream sequencer for the 8x8 dot-product MAC stage. Two LEN-element
// operand buffers (A, B) are loaded through a simple write port while idle.
// On go the block pulses start, waits for the MAC to go busy, streams the
// element pairs (honouring hold bubbles), then waits for the MAC to drop busy
// and captures its result. A watchdog bounds the two handshake waits and
// sticky error flags record dropped writes and timeouts.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en/wr_sel      buffer write strobe, 0 = A, 1 = B
//   wr_addr/wr_data   element index / value
//   go                launch request (ignored outside IDLE)
//   hold              insert a bubble while streaming
//   mac_busy          MAC busy flag
//   mac_result        MAC result
//   start             one-cycle start pulse to the MAC
//   a, b, valid       element pair to the MAC and its qualifier
//   result_out        captured dot product
//   result_valid      one-cycle pulse when result_out updates
//   feeder_busy       high in any state other than IDLE
//   error             sticky: bit0 write dropped while busy, bit1 timeout
module vector_feeder #(
    parameter int DATA_W  = 8,
    parameter int LEN     = 5,
    parameter int IDX_W   = 3,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              go,
    input  logic              hold,
    input  logic              mac_busy,
    input  logic [RES_W-1:0]  mac_result,
    output logic              start,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              valid,
    output logic [RES_W-1:0]  result_out,
    output logic              result_valid,
    output logic              feeder_busy,
    output logic [1:0]        error
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [IDX_W:0]   LEN_L    = (IDX_W + 1)'(LEN);
    // Timer starts at 0 on entry, so TIMEOUT waiting cycles end at TIMEOUT-1.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_STREAM    = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    state_t             state_r, state_next_s;
    logic               start_r, start_next_s;
    logic               valid_r, valid_next_s;
    logic [DATA_W-1:0]  a_r, a_next_s;
    logic [DATA_W-1:0]  b_r, b_next_s;
    logic [RES_W-1:0]   result_r, result_next_s;
    logic               result_valid_r, result_valid_next_s;
    logic               feeder_busy_r;
    logic [1:0]         error_r, error_next_s, error_base_s;
    logic [IDX_W-1:0]   idx_r, idx_next_s;
    logic [TMR_W-1:0]   timer_r, timer_next_s;
    logic               timeout_hit_s;
    logic               wr_drop_s;
    logic               wr_accept_s;

    logic [DATA_W-1:0]  buf_a_r [LEN];
    logic [DATA_W-1:0]  buf_b_r [LEN];

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_next_s        = state_r;
        start_next_s        = 1'b0;
        valid_next_s        = 1'b0;
        a_next_s            = a_r;
        b_next_s            = b_r;
        result_next_s       = result_r;
        result_valid_next_s = 1'b0;
        error_base_s        = error_r;
        idx_next_s          = idx_r;
        timer_next_s        = timer_r;
        timeout_hit_s       = 1'b0;
        wr_accept_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    start_next_s = 1'b1;
                    error_base_s = 2'b00;
                    timer_next_s = {TMR_W{1'b0}};
                    state_next_s = ST_WAIT_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
                // Out-of-range addresses are silently ignored.
                if (wr_en && ({1'b0, wr_addr} < LEN_L)) begin
                    wr_accept_s = 1'b1;
                end else begin
                    wr_accept_s = 1'b0;
                end
            end
            ST_WAIT_BUSY: begin
                if (mac_busy) begin
                    idx_next_s   = {IDX_W{1'b0}};
                    state_next_s = ST_STREAM;
                end else if (timer_r == TMR_LAST) begin
                    timeout_hit_s = 1'b1;
                    state_next_s  = ST_IDLE;
                end else begin
                    timer_next_s = timer_r + TMR_W'(1);
                end
            end
            ST_STREAM: begin
                if (!hold) begin
                    valid_next_s = 1'b1;
                    a_next_s     = buf_a_r[idx_r];
                    b_next_s     = buf_b_r[idx_r];
                    idx_next_s   = idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        state_next_s = ST_DRAIN;
                        timer_next_s = {TMR_W{1'b0}};
                    end else begin
                        state_next_s = ST_STREAM;
                    end
                end else begin
                    valid_next_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!mac_busy) begin
                    result_next_s       = mac_result;
                    result_valid_next_s = 1'b1;
                    state_next_s        = ST_IDLE;
                end else if (timer_r == TMR_LAST) begin
                    timeout_hit_s = 1'b1;
                    state_next_s  = ST_IDLE;
                end else begin
                    timer_next_s = timer_r + TMR_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        wr_drop_s    = wr_en && (state_r != ST_IDLE);
        error_next_s = error_base_s | {timeout_hit_s, wr_drop_s};
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            start_r        <= 1'b0;
            valid_r        <= 1'b0;
            a_r            <= {DATA_W{1'b0}};
            b_r            <= {DATA_W{1'b0}};
            result_r       <= {RES_W{1'b0}};
            result_valid_r <= 1'b0;
            feeder_busy_r  <= 1'b0;
            error_r        <= 2'b00;
            idx_r          <= {IDX_W{1'b0}};
            timer_r        <= {TMR_W{1'b0}};
        end else begin
            state_r        <= state_next_s;
            start_r        <= start_next_s;
            valid_r        <= valid_next_s;
            a_r            <= a_next_s;
            b_r            <= b_next_s;
            result_r       <= result_next_s;
            result_valid_r <= result_valid_next_s;
            feeder_busy_r  <= (state_next_s != ST_IDLE);
            error_r        <= error_next_s;
            idx_r          <= idx_next_s;
            timer_r        <= timer_next_s;
        end
    end

    // Operand buffers; a write in the same cycle as go lands before streaming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LEN; i++) begin
                buf_a_r[i] <= {DATA_W{1'b0}};
                buf_b_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_accept_s) begin
            if (wr_sel) begin
                buf_b_r[wr_addr] <= wr_data;
            end else begin
                buf_a_r[wr_addr] <= wr_data;
            end
        end
    end

    assign start        = start_r;
    assign a            = a_r;
    assign b            = b_r;
    assign valid        = valid_r;
    assign result_out   = result_r;
    assign result_valid = result_valid_r;
    assign feeder_busy  = feeder_busy_r;
    assign error        = error_r;

endmodule

// File: doc/vector_feeder.md
Name: vector_feeder

Overview:
Upstream sequencer for the 8x8 dot-product MAC stage. Holds two LEN-element operand vectors (A, B) in local register buffers loaded through a simple write port. On `go` it pulses the MAC's `start`, streams element pairs with `valid` once the MAC reports busy, then captures the MAC's final result and reports it with a one-cycle `result_valid`. A watchdog and sticky error flags cover handshake failures.

Parameters:
- DATA_W, 8, element width; matches the MAC a/b inputs.
- LEN, 5, elements per vector; must equal the MAC's element count (max_count+1 = 5).
- IDX_W, 3, index width; must satisfy 2^IDX_W >= LEN.
- RES_W, 16, result width; matches the MAC result.
- TIMEOUT, 15, maximum cycles spent in WAIT_BUSY or DRAIN before abort.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = write buffer A, 1 = write buffer B
- wr_addr  in  IDX_W  element index
- wr_data  in  DATA_W  element value
- go  in  1  launch request
- hold  in  1  insert a bubble (valid low) during streaming
- mac_busy  in  1  MAC busy flag
- mac_result  in  RES_W  MAC result
- start  out  1  one-cycle start pulse to the MAC
- a  out  DATA_W  element of A to the MAC
- b  out  DATA_W  element of B to the MAC
- valid  out  1  a/b qualify
- result_out  out  RES_W  captured dot product
- result_valid  out  1  one-cycle pulse; result_out updated
- feeder_busy  out  1  high in any state other than IDLE
- error  out  2  sticky: bit0 = write dropped while busy; bit1 = timeout

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE.
  - start, valid, result_valid, feeder_busy = 0.
  - a, b, result_out, error, idx, timer = 0.
  - Both buffers cleared to 0.
- All outputs are registered.
- Writes:
  - Accepted only in IDLE with wr_addr < LEN; the write takes effect at the sampling edge.
  - wr_addr >= LEN: silently ignored.
  - wr_en while not IDLE: write dropped and error[0] set.
  - A write and `go` in the same IDLE cycle: the write lands first; the new value is streamed.
- States IDLE, WAIT_BUSY, STREAM, DRAIN.
  - IDLE: on go=1: start<=1, error<=0, timer<=0, state<=WAIT_BUSY.
  - WAIT_BUSY:
    - start<=0 after one cycle, so the pulse is exactly 1 cycle wide.
    - mac_busy=1: idx<=0, state<=STREAM.
    - timer reaches TIMEOUT: error[1]<=1, state<=IDLE.
  - STREAM:
    - hold=0: valid<=1, a<=A[idx], b<=B[idx], idx<=idx+1.
    - If idx==LEN-1 on that issue: state<=DRAIN, timer<=0.
    - hold=1: valid<=0; idx is unchanged.
    - No timeout in STREAM.
  - DRAIN:
    - valid<=0.
    - mac_busy=0: result_out<=mac_result, result_valid<=1 (one cycle), state<=IDLE.
    - timer reaches TIMEOUT: error[1]<=1, state<=IDLE, result_valid stays 0.
- `go` outside IDLE is ignored.
- Latency with hold=0 and a compliant MAC:
  - go sampled at edge E; start high in cycle E..E+1.
  - First valid issued at edge E+3; last valid at edge E+LEN+2.
  - result_valid issued at edge E+LEN+4 (E+9 for LEN=5).
  - Each hold cycle adds 1.
- Arithmetic: none locally. result_out is the MAC's RES_W value, i.e. the sum modulo 2^RES_W.

Test Plan:
- Load A=[1,2,3,4,5], B=[6,7,8,9,10], go, hold=0 → start pulse 1 cycle; five valid beats with pairs (1,6)…(5,10); result_out=130, result_valid at edge go+9; error=0.
- All elements 255 in both vectors → result_out=62981 (325125 mod 65536).
- Same as the first scenario with hold=1 on the 2nd and 4th STREAM cycles → valid low on those cycles; no element skipped or repeated; result_out=130 at edge go+11.
- MAC stubbed with mac_busy stuck 0 → WAIT_BUSY times out after 15 cycles; error=2'b10; valid never asserted; feeder returns to IDLE; next go clears error.
- wr_en during STREAM and a second go during STREAM → buffer unchanged, error[0]=1, no second start pulse; wr_addr=6 in IDLE → ignored.
- Assert reset in the middle of STREAM (after the 3rd beat) → start, valid, feeder_busy go low immediately; buffers read back 0; a subsequent full load+go produces a correct result.
